// File: rtl/md5_core_scheduler.sv
// md5_core_scheduler
//
// Feeds candidate strings from the string buffer to a bank of md5 cores, round-robin over idle
// cores, and compares each returned digest against the latched target hash. Reports the first
// matching candidate index and job completion toward the bus front end.
//
// Optional feature macro: MD5_MATCH_COUNT_EN
//   defined   : adds the MATCH_CNT_W parameter and the match_cnt output, a saturating count of
//               every matching digest in the current job.
//   undefined : no match_cnt port, no counter logic.
//
// Ports
//   clk, reset_n  clock, asynchronous active-low reset
//   cmd_start     pulse: begin a job (taken only in idle/done), latches target_hash
//   cmd_abort     pulse: stop accepting candidates, let outstanding cores drain
//   target_hash   digest to search for
//   cand_valid    candidate available; cand_last marks the final one; cand_idx is its index
//   cand_ready    candidate accepted this cycle when cand_valid is also high
//   core_start    one-hot, one-cycle start pulse (also the data-mux load strobe)
//   core_done     per-core one-cycle digest-valid pulse; core_digest core i at [128*i +: 128]
//   busy          job running or draining
//   done          job finished, held until the next taken cmd_start
//   match         sticky: some digest matched during this job
//   match_idx     candidate index of the first match
//   match_cnt     number of matches in this job (MD5_MATCH_COUNT_EN only)

module md5_core_scheduler #(
  parameter int unsigned NUM_CORES     = 4,
  parameter int unsigned IDX_W         = 16,
  parameter int unsigned STOP_ON_MATCH = 1
`ifdef MD5_MATCH_COUNT_EN
  ,
  parameter int unsigned MATCH_CNT_W   = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_start,
  input  logic                     cmd_abort,
  input  logic [127:0]             target_hash,
  input  logic                     cand_valid,
  input  logic                     cand_last,
  input  logic [IDX_W-1:0]         cand_idx,
  output logic                     cand_ready,
  output logic [NUM_CORES-1:0]     core_start,
  input  logic [NUM_CORES-1:0]     core_done,
  input  logic [128*NUM_CORES-1:0] core_digest,
  output logic                     busy,
  output logic                     done,
  output logic                     match,
  output logic [IDX_W-1:0]         match_idx
`ifdef MD5_MATCH_COUNT_EN
  ,
  output logic [MATCH_CNT_W-1:0]   match_cnt
`endif
);

  localparam int unsigned PtrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 state_q;
  logic [NUM_CORES-1:0]   assigned_q;
  logic [IDX_W-1:0]       idx_q [NUM_CORES];
  logic [PtrW-1:0]        rr_ptr_q;
  logic [127:0]           target_q;
  logic [NUM_CORES-1:0]   core_start_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   match_q;
  logic [IDX_W-1:0]       match_idx_q;

  logic                   accept;
  logic                   dispatch;
  logic                   start_taken;
  logic [NUM_CORES-1:0]   retire;
  logic                   sel_found;
  logic [PtrW-1:0]        sel;
  logic [PtrW-1:0]        cand_core;
  logic [NUM_CORES-1:0]   sel_onehot;
  logic [NUM_CORES-1:0]   hits;
  logic                   any_hit;
  logic [PtrW-1:0]        first_hit;

  // Abort wins over a same-cycle candidate: ready is suppressed so nothing is accepted.
  assign cand_ready  = (state_q == StRun) & ~(&assigned_q) & ~cmd_abort;
  assign accept      = cand_valid & cand_ready;
  assign dispatch    = accept & sel_found;
  assign start_taken = cmd_start & ((state_q == StIdle) | (state_q == StDone));

  // A done pulse only counts for a core that actually holds a candidate.
  assign retire = core_done & assigned_q;

  // First free core scanning upward from rr_ptr with wrap. Uses registered assigned bits only,
  // so a core freed this cycle is not reused until the next one.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    cand_core = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand_core = PtrW'((32'(rr_ptr_q) + k) % NUM_CORES);
      if (!sel_found && !assigned_q[cand_core]) begin
        sel_found = 1'b1;
        sel       = cand_core;
      end
    end
    sel_onehot = NUM_CORES'(1) << sel;
  end

  // Digest compare; lowest-index hit supplies match_idx when several land together.
  always_comb begin
    hits = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      hits[i] = retire[i] && (core_digest[128*i +: 128] == target_q);
    end
    any_hit   = |hits;
    first_hit = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hits[i]) first_hit = PtrW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      assigned_q   <= '0;
      rr_ptr_q     <= '0;
      target_q     <= '0;
      core_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      match_idx_q  <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      core_start_q <= '0;
      assigned_q   <= (assigned_q & ~retire) | (dispatch ? sel_onehot : '0);

      if (dispatch) begin
        idx_q[sel]   <= cand_idx;
        core_start_q <= sel_onehot;
        rr_ptr_q     <= (sel == PtrW'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
      end

      if (any_hit) begin
        match_q <= 1'b1;
        if (!match_q) match_idx_q <= idx_q[first_hit];
      end

      case (state_q)
        StIdle, StDone: begin
          if (cmd_start) begin
            state_q     <= StRun;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
            target_q    <= target_hash;
          end
        end
        StRun: begin
          // A candidate accepted alongside cand_last or a match is still dispatched above.
          if ((accept && cand_last) || cmd_abort || (any_hit && (STOP_ON_MATCH != 0))) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if ((assigned_q == '0) && (core_start_q == '0)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign match      = match_q;
  assign match_idx  = match_idx_q;

`ifdef MD5_MATCH_COUNT_EN
  logic [MATCH_CNT_W-1:0] match_cnt_q;
  logic [MATCH_CNT_W-1:0] match_cnt_sum;
  logic [MATCH_CNT_W+4:0] cnt_wide;

  // Add the popcount of this cycle's hits, saturating at all-ones.
  always_comb begin
    cnt_wide = {5'd0, match_cnt_q};
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cnt_wide = cnt_wide + {{(MATCH_CNT_W + 4){1'b0}}, hits[i]};
    end
    match_cnt_sum = (|cnt_wide[MATCH_CNT_W+4:MATCH_CNT_W]) ? '1 : cnt_wide[MATCH_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt_q <= '0;
    end else if (start_taken) begin
      match_cnt_q <= '0;
    end else if (any_hit) begin
      match_cnt_q <= match_cnt_sum;
    end
  end

  assign match_cnt = match_cnt_q;
`endif

endmodule
